// File: rtl/clksplit_multi.sv
// clksplit_multi: multi-channel programmable clock-enable generator.
// Each channel emits a periodic enable level (cke) and a period-start pulse
// (tick). New period/high-time settings are staged in a shadow register and
// take effect only at a period boundary, so the output never glitches.
// Optional build macro: CLKSPLIT_SYNC_EN adds a 'sync' input that restarts
// the phase of every running channel at once.
module clksplit_multi #(
  parameter int CH         = 4,
  parameter int W          = 26,
  parameter int DEF_PERIOD = 50000000,
  parameter int DEF_HIGH   = 25000000,
  localparam int CW        = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst_,
`ifdef CLKSPLIT_SYNC_EN
  input  logic          sync,
`endif
  input  logic [CH-1:0] ena,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_ch,
  input  logic [W-1:0]  cfg_period,
  input  logic [W-1:0]  cfg_high,
  output logic [CH-1:0] cke,
  output logic [CH-1:0] tick,
  output logic [CH-1:0] pending
);

  localparam logic [W-1:0] RST_PERIOD = W'(DEF_PERIOD);
  localparam logic [W-1:0] RST_HIGH   = W'(DEF_HIGH);

  // A write addressed past the last channel must not touch any state, even
  // when the select field is wide enough to encode such an index.
  logic cfg_valid;
  assign cfg_valid = (32'(cfg_ch) < 32'(CH));

  for (genvar i = 0; i < CH; i++) begin : g_ch
    localparam logic [CW-1:0] IDX = CW'(i);

    logic [W-1:0] cnt;
    logic [W-1:0] p_act;
    logic [W-1:0] h_act;
    logic [W-1:0] p_sh;
    logic [W-1:0] h_sh;
    logic         pend_r;
    logic         cke_r;
    logic         tick_r;

    logic wr;
    logic run;
    logic wrap;
    logic boundary;
    logic apply;

    // A channel only counts while enabled and not halted by a zero period.
    assign wr   = cfg_we && cfg_valid && (cfg_ch == IDX);
    assign run  = ena[i] && (p_act != '0);
    assign wrap = run && (cnt == (p_act - W'(1)));

`ifdef CLKSPLIT_SYNC_EN
    // sync makes every running channel behave as if it were at its wrap edge.
    assign boundary = wrap || (run && sync);
`else
    assign boundary = wrap;
`endif

    // Idle channels take staged settings at once; running ones only at a boundary.
    assign apply = boundary || !run;

    // Phase counter: restarts on idle or boundary, otherwise advances by one.
    always_ff @(posedge clk) begin
      if (rst_) begin
        cnt <= '0;
      end else if (!run || boundary) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + W'(1);
      end
    end

    // Shadow/active configuration; the apply uses the shadow as it stood
    // before this edge, so a write landing on an apply edge stays pending.
    always_ff @(posedge clk) begin
      if (rst_) begin
        p_act  <= RST_PERIOD;
        h_act  <= RST_HIGH;
        p_sh   <= RST_PERIOD;
        h_sh   <= RST_HIGH;
        pend_r <= 1'b0;
      end else begin
        if (apply && pend_r) begin
          p_act <= p_sh;
          h_act <= h_sh;
        end
        if (wr) begin
          p_sh   <= cfg_period;
          h_sh   <= cfg_high;
          pend_r <= 1'b1;
        end else if (apply) begin
          pend_r <= 1'b0;
        end
      end
    end

    // Registered outputs derived from the counter value present at this edge.
    always_ff @(posedge clk) begin
      if (rst_) begin
        cke_r  <= 1'b0;
        tick_r <= 1'b0;
      end else begin
        cke_r  <= run && (cnt < h_act);
        tick_r <= run && (cnt == '0);
      end
    end

    assign cke[i]     = cke_r;
    assign tick[i]    = tick_r;
    assign pending[i] = pend_r;
  end

endmodule

// File: tb/tb_clksplit_multi.sv
// tb_clksplit_multi: directed self-checking bench for clksplit_multi.
// Built with CH=5 so that an out-of-range channel index (5, 7) is encodable.
// Small reset defaults (P=12, H=5) keep the reset-configuration check short.
// With CLKSPLIT_SYNC_EN defined the sync port is driven and checked as well.
module tb_clksplit_multi;

  localparam int CH = 5;
  localparam int W  = 26;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_;
`ifdef CLKSPLIT_SYNC_EN
  logic          sync;
`endif
  logic [CH-1:0] ena;
  logic          cfg_we;
  logic [CW-1:0] cfg_ch;
  logic [W-1:0]  cfg_period;
  logic [W-1:0]  cfg_high;
  logic [CH-1:0] cke;
  logic [CH-1:0] tick;
  logic [CH-1:0] pending;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int s0     = 0;

  clksplit_multi #(
    .CH(CH),
    .W(W),
    .DEF_PERIOD(12),
    .DEF_HIGH(5)
  ) dut (
    .clk(clk),
    .rst_(rst_),
`ifdef CLKSPLIT_SYNC_EN
    .sync(sync),
`endif
    .ena(ena),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_period(cfg_period),
    .cfg_high(cfg_high),
    .cke(cke),
    .tick(tick),
    .pending(pending)
  );

  // Free-running 10 ns system clock.
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [CW-1:0] ch,
                               input logic [W-1:0] p, input logic [W-1:0] h);
    cfg_we     = we;
    cfg_ch     = ch;
    cfg_period = p;
    cfg_high   = h;
  endtask

  // Write one idle channel and let the following idle edge apply it.
  task automatic cfgIdle(input logic [CW-1:0] ch, input logic [W-1:0] p, input logic [W-1:0] h);
    applyStimulus(1'b1, ch, p, h);
    step();
    applyStimulus(1'b0, '0, '0, '0);
    step();
  endtask

  // Channel 0 runs P=10, H=3 continuously from edge s0 onward.
  task automatic checkCh0(input string tag);
    int k;
    k = (edge_n - s0 - 1) % 10;
    checkOutput({tag, "_cke0"}, 32'(cke[0]), 32'(k < 3));
    checkOutput({tag, "_tick0"}, 32'(tick[0]), 32'(k == 0));
  endtask

  // Directed sequence.
  initial begin
    int ones;
    int ticks;
    int cnt0;

    rst_ = 1'b1;
    ena  = '0;
`ifdef CLKSPLIT_SYNC_EN
    sync = 1'b0;
`endif
    applyStimulus(1'b0, '0, '0, '0);
    step();
    step();
    checkOutput("reset_cke", 32'(cke), 32'h0);
    checkOutput("reset_tick", 32'(tick), 32'h0);
    checkOutput("reset_pending", 32'(pending), 32'h0);
    rst_ = 1'b0;

    // Reset defaults P=12, H=5 on channel 4: 5 high cycles, 1 tick per period.
    ena = 5'b10000;
    ones = 0;
    ticks = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 0) checkOutput("def_first_tick", 32'(tick[4]), 32'h1);
      ones  += int'(cke[4]);
      ticks += int'(tick[4]);
    end
    checkOutput("def_high_count", 32'(ones), 32'd5);
    checkOutput("def_tick_count", 32'(ticks), 32'd1);
    ena = '0;
    step();
    checkOutput("def_off_cke", 32'(cke), 32'h0);

    // Channel 0: P=10, H=3 written and applied while idle.
    applyStimulus(1'b1, 3'd0, 26'd10, 26'd3);
    step();
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("t1_pend_set", 32'(pending), 32'h01);
    step();
    checkOutput("t1_pend_clr", 32'(pending), 32'h00);
    ena[0] = 1'b1;
    s0 = edge_n;
    for (int k = 0; k < 25; k++) begin
      step();
      checkCh0("t1");
    end

    // Channel 1: P=8, H=4 running; P=4, H=1 written at cnt=2.
    cfgIdle(3'd1, 26'd8, 26'd4);
    ena[1] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 2) applyStimulus(1'b1, 3'd1, 26'd4, 26'd1);
      step();
      applyStimulus(1'b0, '0, '0, '0);
      checkOutput("t2_cke1", 32'(cke[1]), 32'((k < 8) ? (k < 4) : ((k - 8) % 4 == 0)));
      checkOutput("t2_tick1", 32'(tick[1]), 32'((k < 8) ? (k == 0) : ((k - 8) % 4 == 0)));
      checkOutput("t2_pend1", 32'(pending[1]), 32'((k >= 2) && (k <= 6)));
      checkCh0("t2");
    end
    ena[1] = 1'b0;

    // Channel 2: P=5, H=2; write P=3, H=3 exactly on the wrap edge (cnt=4).
    cfgIdle(3'd2, 26'd5, 26'd2);
    ena[2] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (k == 4) applyStimulus(1'b1, 3'd2, 26'd3, 26'd3);
      step();
      applyStimulus(1'b0, '0, '0, '0);
      checkOutput("t3_cke2", 32'(cke[2]), 32'((k < 10) ? (k % 5 < 2) : 1));
      checkOutput("t3_tick2", 32'(tick[2]), 32'((k < 10) ? (k % 5 == 0) : ((k - 10) % 3 == 0)));
      checkOutput("t3_pend2", 32'(pending[2]), 32'((k >= 4) && (k <= 8)));
    end
    ena[2] = 1'b0;

    // Channel 3 degenerate values: P=0 halts the channel.
    cfgIdle(3'd3, 26'd0, 26'd4);
    ena[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checkOutput("p0_cke3", 32'(cke[3]), 32'h0);
      checkOutput("p0_tick3", 32'(tick[3]), 32'h0);
    end
    // P=1, H=1: a halted channel applies at once even with ena high.
    cfgIdle(3'd3, 26'd1, 26'd1);
    checkOutput("p1_pend3", 32'(pending[3]), 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      checkOutput("p1_cke3", 32'(cke[3]), 32'h1);
      checkOutput("p1_tick3", 32'(tick[3]), 32'h1);
    end
    // H=0 with P=4: enable never rises.
    ena[3] = 1'b0;
    cfgIdle(3'd3, 26'd4, 26'd0);
    ena[3] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      checkOutput("h0_cke3", 32'(cke[3]), 32'h0);
      checkOutput("h0_tick3", 32'(tick[3]), 32'(k % 4 == 0));
    end
    // H=20 with P=5: enable held high.
    ena[3] = 1'b0;
    cfgIdle(3'd3, 26'd5, 26'd20);
    ena[3] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      checkOutput("hbig_cke3", 32'(cke[3]), 32'h1);
      checkOutput("hbig_tick3", 32'(tick[3]), 32'(k % 5 == 0));
    end
    ena[3] = 1'b0;
    step();

    // Out-of-range channel index: nothing pends, channel 0 keeps its phase.
    applyStimulus(1'b1, 3'd5, 26'd2, 26'd1);
    step();
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("bad5_pending", 32'(pending), 32'h0);
    checkCh0("bad5");
    applyStimulus(1'b1, 3'd7, 26'd2, 26'd1);
    step();
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("bad7_pending", 32'(pending), 32'h0);
    checkCh0("bad7");
    for (int k = 0; k < 12; k++) begin
      step();
      checkCh0("after_bad");
    end

    // Drop ena[0] while cnt=1 (cke would still be high) and restart.
    for (int k = 0; k < 10; k++) begin
      cnt0 = (edge_n - s0) % 10;
      if (cnt0 == 1) break;
      step();
    end
    checkOutput("drop_phase", 32'((edge_n - s0) % 10), 32'd1);
    ena[0] = 1'b0;
    step();
    checkOutput("drop_cke0", 32'(cke[0]), 32'h0);
    checkOutput("drop_tick0", 32'(tick[0]), 32'h0);
    ena[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      checkOutput("restart_cke0", 32'(cke[0]), 32'(k % 10 < 3));
      checkOutput("restart_tick0", 32'(tick[0]), 32'(k % 10 == 0));
    end

`ifdef CLKSPLIT_SYNC_EN
    // Channels 0 (P=6) and 1 (P=9) at unrelated phases, then aligned by sync.
    ena = '0;
    cfgIdle(3'd0, 26'd6, 26'd3);
    cfgIdle(3'd1, 26'd9, 26'd4);
    ena[0] = 1'b1;
    step();
    step();
    ena[1] = 1'b1;
    step();
    step();
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    step();
    checkOutput("sync_tick0", 32'(tick[0]), 32'h1);
    checkOutput("sync_tick1", 32'(tick[1]), 32'h1);
    step();
    checkOutput("sync_next_tick", 32'(tick[1:0]), 32'h0);
    checkOutput("sync_next_cke", 32'(cke[1:0]), 32'h3);
    applyStimulus(1'b1, 3'd1, 26'd3, 26'd1);
    step();
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("sync_pend1", 32'(pending[1]), 32'h1);
    sync = 1'b1;
    rst_ = 1'b1;
    step();
    checkOutput("sync_rst_cke", 32'(cke), 32'h0);
    checkOutput("sync_rst_tick", 32'(tick), 32'h0);
    checkOutput("sync_rst_pending", 32'(pending), 32'h0);
    sync = 1'b0;
    rst_ = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
